hazard_unit_mc: RTL and testbench
=================================

Name: hazard_unit_mc

Overview:
Second-generation hazard unit for the 5-stage RV32I pipeline, extended for an M-extension multicycle multiply/divide unit in EX and a data memory that can wait-state. It keeps M/W forwarding, load-use stalling and branch flushing. It adds the following:
- a multicycle-op state machine with a latency watchdog;
- memory wait stalls that freeze the whole pipe;
- saturating performance counters for stall cycles and redirects.

Parameters:
REG_AW, 5, register address width
MC_TIMEOUT, 64, maximum RUN cycles before the watchdog fires (at least 2)
MC_CW, 7, width of the multicycle cycle counter (2^MC_CW must be greater than MC_TIMEOUT)
CNT_W, 32, width of the performance counters

Ports:
i_clk  in  1  clock, rising edge
i_rstn  in  1  synchronous active-low reset
i_regfile_rs1_addrD  in  REG_AW  rs1 address in Decode
i_regfile_rs2_addrD  in  REG_AW  rs2 address in Decode
i_use_rs1D  in  1  Decode instruction reads rs1
i_use_rs2D  in  1  Decode instruction reads rs2
i_regfile_rs1_addrE  in  REG_AW  rs1 address in Execute
i_regfile_rs2_addrE  in  REG_AW  rs2 address in Execute
i_regfile_rd_addrE  in  REG_AW  rd address in Execute
i_regfile_rd_addrM  in  REG_AW  rd address in Memory
i_regfile_rd_addrW  in  REG_AW  rd address in Writeback
i_ctrl_result_srcE  in  1  Execute instruction is a load
i_ctrl_reg_wr_enM  in  1  Memory stage writes rd
i_ctrl_reg_wr_enW  in  1  Writeback stage writes rd
i_PCSrcE  in  2  nonzero means a redirect is resolved in Execute
i_mc_opE  in  1  Execute holds a mul/div op
i_mc_done  in  1  mul/div result valid this cycle
i_dmem_reqM  in  1  Memory stage has a load or store
i_dmem_ready  in  1  data memory accepts or completes this cycle
i_cnt_clr  in  1  synchronous clear of the performance counters
o_hazard_forwardAE  out  2  forward select for operand A: 10 from M, 01 from W, 00 from the register file
o_hazard_forwardBE  out  2  forward select for operand B, same encoding
o_hazard_stallF  out  1  hold the PC
o_hazard_stallD  out  1  hold the IF/ID register
o_hazard_stallE  out  1  hold the ID/EX register
o_hazard_stallM  out  1  hold the EX/MEM register
o_hazard_flushD  out  1  bubble into Decode
o_hazard_flushE  out  1  bubble into Execute
o_hazard_flushM  out  1  bubble into Memory
o_hazard_flushW  out  1  bubble into Writeback
o_redirect  out  1  PC may take the branch target this cycle
o_mc_start  out  1  one-cycle start pulse to the mul/div unit
o_mc_timeout  out  1  one-cycle watchdog pulse
o_stall_cycles  out  CNT_W  saturating count of cycles with stallF high
o_redirect_count  out  CNT_W  saturating count of redirects

Behaviour:
- Reset (i_rstn low at a clock edge):
  - FSM goes to IDLE; counters and the mc cycle counter go to 0.
  - While i_rstn is low, every stall, flush, o_redirect, o_mc_start and o_mc_timeout output is forced to 0, and both forward selects are 00.
- Forwarding (combinational):
  - M match has priority over W match.
  - A match requires the source address nonzero and the matching stage's write enable high.
- Define mem_stall = i_dmem_reqM and not i_dmem_ready.
- Define lw_stall = i_ctrl_result_srcE, rd_addrE nonzero, and a Decode match (rs1D matches rd_addrE with i_use_rs1D, or rs2D matches rd_addrE with i_use_rs2D).
- MC FSM states are IDLE and RUN:
  - IDLE to RUN: i_mc_opE and not mem_stall. o_mc_start=1 in that cycle.
  - RUN to IDLE on i_mc_done; the result is accepted that cycle.
  - RUN to IDLE when the counter reaches MC_TIMEOUT-1 without done; o_mc_timeout=1 for that cycle.
  - The counter clears on entry to RUN and increments each RUN cycle.
  - mem_stall does not pause the counter.
- Define mc_stall = i_mc_opE and not (RUN with i_mc_done) and not (RUN timeout cycle).
- Output priority (highest first):
  1. mem_stall: stallF/D/E/M=1, flushW=1, all other flushes 0, o_redirect=0.
  2. mc_stall: stallF/D/E=1, flushM=1.
  3. Redirect (i_PCSrcE nonzero): o_redirect=1, flushD=1, flushE=1.
  4. lw_stall: stallF/D=1, flushE=1.
- Outputs not driven by the active case are 0.
- Redirect and lw_stall cannot coexist, because a load is not a branch. If both are asserted, redirect wins.
- Timeout cycle: stalls are released, the Execute op advances with undefined data, and the core takes the trap.
- Counters:
  - They saturate at all-ones.
  - i_cnt_clr has priority over increment.
  - They update on the clock edge after the counted cycle.

Decomposition:
- The shared package holds the forward-select encodings (FWD_RF=00, FWD_W=01, FWD_M=10) and the MC state encoding.
- One sub-module, hazard_sat_counter (CNT_W wide: clr, inc, saturating), is instantiated twice.

Test Plan:
- Forwarding: rs1E=5, rdM=5 with wr_enM, and rdW=5 with wr_enW → forwardAE=10. With rs1E=0 under the same matches → 00.
- Load-use: load in E with rdE=7, rs2D=7, use_rs2D=1 → stallF=stallD=flushE=1 for one cycle. Repeat with use_rs2D=0 → no stall.
- Multicycle: mc_opE held high, done after 5 cycles → o_mc_start pulses once. stallF/D/E and flushM are high for 5 cycles and drop on the done cycle. FSM returns to IDLE.
- Watchdog: MC_TIMEOUT=8 with done never asserted → o_mc_timeout pulses on RUN cycle 8 and stalls release that cycle.
- Memory wait during RUN: dmem_ready low for 3 cycles → all four stalls and flushW high, o_redirect=0, and the mc counter keeps running.
- Counters: 10 stall cycles then i_cnt_clr → o_stall_cycles reads 10, then 0. With CNT_W=4 and 20 redirects → o_redirect_count holds at 15.

Source files
------------

// File: rtl/hazard_unit_mc_pkg.sv
// Shared encodings for the multicycle-aware hazard unit: forward selects and mul/div FSM states.
package hazard_unit_mc_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    typedef enum logic {
        McIdle = 1'b0,
        McRun  = 1'b1
    } mc_state_t;

endpackage

// File: rtl/hazard_sat_counter.sv
// Saturating up-counter with a synchronous clear that takes priority over increment.
module hazard_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != '1)) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit for the 5-stage RV32I pipe: forwarding, load-use, redirects, mul/div sequencing
// with a latency watchdog, data-memory wait stalls and saturating performance counters.
module hazard_unit_mc
    import hazard_unit_mc_pkg::*;
#(
    parameter int unsigned REG_AW     = 5,
    parameter int unsigned MC_TIMEOUT = 64,
    parameter int unsigned MC_CW      = 7,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [REG_AW-1:0] i_regfile_rs1_addrD,
    input  logic [REG_AW-1:0] i_regfile_rs2_addrD,
    input  logic              i_use_rs1D,
    input  logic              i_use_rs2D,
    input  logic [REG_AW-1:0] i_regfile_rs1_addrE,
    input  logic [REG_AW-1:0] i_regfile_rs2_addrE,
    input  logic [REG_AW-1:0] i_regfile_rd_addrE,
    input  logic [REG_AW-1:0] i_regfile_rd_addrM,
    input  logic [REG_AW-1:0] i_regfile_rd_addrW,
    input  logic              i_ctrl_result_srcE,
    input  logic              i_ctrl_reg_wr_enM,
    input  logic              i_ctrl_reg_wr_enW,
    input  logic [1:0]        i_PCSrcE,
    input  logic              i_mc_opE,
    input  logic              i_mc_done,
    input  logic              i_dmem_reqM,
    input  logic              i_dmem_ready,
    input  logic              i_cnt_clr,
    output logic [1:0]        o_hazard_forwardAE,
    output logic [1:0]        o_hazard_forwardBE,
    output logic              o_hazard_stallF,
    output logic              o_hazard_stallD,
    output logic              o_hazard_stallE,
    output logic              o_hazard_stallM,
    output logic              o_hazard_flushD,
    output logic              o_hazard_flushE,
    output logic              o_hazard_flushM,
    output logic              o_hazard_flushW,
    output logic              o_redirect,
    output logic              o_mc_start,
    output logic              o_mc_timeout,
    output logic [CNT_W-1:0]  o_stall_cycles,
    output logic [CNT_W-1:0]  o_redirect_count
);

    localparam logic [MC_CW-1:0] MC_LAST = MC_CW'(MC_TIMEOUT - 1);

    mc_state_t        r_state;
    logic [MC_CW-1:0] r_mc_cnt;

    logic w_mem_stall, w_lw_stall, w_mc_stall, w_run;
    logic w_mc_accept, w_mc_to, w_mc_start;

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        logic [1:0] sel;
        sel = FWD_RF;
        if (src != '0) begin
            if (i_ctrl_reg_wr_enM && (src == i_regfile_rd_addrM)) begin
                sel = FWD_M;
            end else if (i_ctrl_reg_wr_enW && (src == i_regfile_rd_addrW)) begin
                sel = FWD_W;
            end
        end
        return sel;
    endfunction

    assign w_mem_stall = i_dmem_reqM & ~i_dmem_ready;
    assign w_lw_stall  = i_ctrl_result_srcE & (i_regfile_rd_addrE != '0) &
                         ((i_use_rs1D & (i_regfile_rs1_addrD == i_regfile_rd_addrE)) |
                          (i_use_rs2D & (i_regfile_rs2_addrD == i_regfile_rd_addrE)));

    assign w_run       = (r_state == McRun);
    assign w_mc_accept = w_run & i_mc_done;
    assign w_mc_to     = w_run & ~i_mc_done & (r_mc_cnt == MC_LAST);
    assign w_mc_start  = ~w_run & i_mc_opE & ~w_mem_stall;
    assign w_mc_stall  = i_mc_opE & ~w_mc_accept & ~w_mc_to;

    // Counter keeps running through memory waits so the watchdog bounds wall-clock latency.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_state  <= McIdle;
            r_mc_cnt <= '0;
        end else if (w_mc_start) begin
            r_state  <= McRun;
            r_mc_cnt <= '0;
        end else if (w_run) begin
            if (w_mc_accept || w_mc_to) begin
                r_state <= McIdle;
            end else begin
                r_mc_cnt <= r_mc_cnt + MC_CW'(1);
            end
        end
    end

    always_comb begin
        o_hazard_forwardAE = FWD_RF;
        o_hazard_forwardBE = FWD_RF;
        o_hazard_stallF    = 1'b0;
        o_hazard_stallD    = 1'b0;
        o_hazard_stallE    = 1'b0;
        o_hazard_stallM    = 1'b0;
        o_hazard_flushD    = 1'b0;
        o_hazard_flushE    = 1'b0;
        o_hazard_flushM    = 1'b0;
        o_hazard_flushW    = 1'b0;
        o_redirect         = 1'b0;
        o_mc_start         = 1'b0;
        o_mc_timeout       = 1'b0;
        if (i_rstn) begin
            o_hazard_forwardAE = fwd_sel(i_regfile_rs1_addrE);
            o_hazard_forwardBE = fwd_sel(i_regfile_rs2_addrE);
            o_mc_start         = w_mc_start;
            o_mc_timeout       = w_mc_to;
            if (w_mem_stall) begin
                o_hazard_stallF = 1'b1;
                o_hazard_stallD = 1'b1;
                o_hazard_stallE = 1'b1;
                o_hazard_stallM = 1'b1;
                o_hazard_flushW = 1'b1;
            end else if (w_mc_stall) begin
                o_hazard_stallF = 1'b1;
                o_hazard_stallD = 1'b1;
                o_hazard_stallE = 1'b1;
                o_hazard_flushM = 1'b1;
            end else if (i_PCSrcE != 2'b00) begin
                o_redirect      = 1'b1;
                o_hazard_flushD = 1'b1;
                o_hazard_flushE = 1'b1;
            end else if (w_lw_stall) begin
                o_hazard_stallF = 1'b1;
                o_hazard_stallD = 1'b1;
                o_hazard_flushE = 1'b1;
            end
        end
    end

    hazard_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_clr   (i_cnt_clr),
        .i_inc   (o_hazard_stallF),
        .o_count (o_stall_cycles)
    );

    hazard_sat_counter #(
        .CNT_W (CNT_W)
    ) u_redirect_cnt (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .i_clr   (i_cnt_clr),
        .i_inc   (o_redirect),
        .o_count (o_redirect_count)
    );

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Scoreboard bench for hazard_unit_mc: directed scenarios plus random traffic against a
// cycle-level reference model of the hazard rules.
module tb_hazard_unit_mc;

    localparam int unsigned REG_AW     = 5;
    localparam int unsigned MC_TIMEOUT = 8;
    localparam int unsigned MC_CW      = 4;
    localparam int unsigned CNT_W      = 4;
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rstn;
    logic [REG_AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic              use1, use2, resE, wenM, wenW;
    logic [1:0]        pcsrc;
    logic              mc_op, mc_done, dreq, drdy, clr;

    logic [1:0]       fwdA, fwdB;
    logic             stF, stD, stE, stM, flD, flE, flM, flW;
    logic             redir, mstart, mto;
    logic [CNT_W-1:0] scnt, rcnt;

    hazard_unit_mc #(
        .REG_AW     (REG_AW),
        .MC_TIMEOUT (MC_TIMEOUT),
        .MC_CW      (MC_CW),
        .CNT_W      (CNT_W)
    ) dut (
        .i_clk               (clk),
        .i_rstn              (rstn),
        .i_regfile_rs1_addrD (rs1D),
        .i_regfile_rs2_addrD (rs2D),
        .i_use_rs1D          (use1),
        .i_use_rs2D          (use2),
        .i_regfile_rs1_addrE (rs1E),
        .i_regfile_rs2_addrE (rs2E),
        .i_regfile_rd_addrE  (rdE),
        .i_regfile_rd_addrM  (rdM),
        .i_regfile_rd_addrW  (rdW),
        .i_ctrl_result_srcE  (resE),
        .i_ctrl_reg_wr_enM   (wenM),
        .i_ctrl_reg_wr_enW   (wenW),
        .i_PCSrcE            (pcsrc),
        .i_mc_opE            (mc_op),
        .i_mc_done           (mc_done),
        .i_dmem_reqM         (dreq),
        .i_dmem_ready        (drdy),
        .i_cnt_clr           (clr),
        .o_hazard_forwardAE  (fwdA),
        .o_hazard_forwardBE  (fwdB),
        .o_hazard_stallF     (stF),
        .o_hazard_stallD     (stD),
        .o_hazard_stallE     (stE),
        .o_hazard_stallM     (stM),
        .o_hazard_flushD     (flD),
        .o_hazard_flushE     (flE),
        .o_hazard_flushM     (flM),
        .o_hazard_flushW     (flW),
        .o_redirect          (redir),
        .o_mc_start          (mstart),
        .o_mc_timeout        (mto),
        .o_stall_cycles      (scnt),
        .o_redirect_count    (rcnt)
    );

    // st = {F,D,E,M}, fl = {D,E,M,W}
    typedef struct packed {
        logic [1:0]       fa;
        logic [1:0]       fb;
        logic [3:0]       st;
        logic [3:0]       fl;
        logic             redir;
        logic             start;
        logic             tout;
        logic [CNT_W-1:0] sc;
        logic [CNT_W-1:0] rc;
    } exp_t;

    exp_t q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    // Reference model state: busy flag, 1-based RUN cycle number, counter values.
    bit m_busy;
    int m_run_cycle;
    int m_sc;
    int m_rc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] src);
        if (src == 0) return 2'b00;
        if (wenM && src == rdM) return 2'b10;
        if (wenW && src == rdW) return 2'b01;
        return 2'b00;
    endfunction

    // Compute this cycle's expected outputs, push them, advance the model, step one clock.
    task automatic issue();
        exp_t e;
        bit   mem, done_now, to_now, start, mcst, lw;
        e    = '0;
        e.sc = CNT_W'(m_sc);
        e.rc = CNT_W'(m_rc);
        if (!rstn) begin
            m_busy = 0; m_run_cycle = 0; m_sc = 0; m_rc = 0;
        end else begin
            e.fa     = ref_fwd(rs1E);
            e.fb     = ref_fwd(rs2E);
            mem      = dreq && !drdy;
            done_now = m_busy && mc_done;
            to_now   = m_busy && !mc_done && (m_run_cycle == MC_TIMEOUT);
            start    = !m_busy && mc_op && !mem;
            mcst     = mc_op && !done_now && !to_now;
            lw       = resE && (rdE != 0) &&
                       ((use1 && rs1D == rdE) || (use2 && rs2D == rdE));
            if (mem) begin
                e.st = 4'b1111; e.fl = 4'b0001;
            end else if (mcst) begin
                e.st = 4'b1110; e.fl = 4'b0010;
            end else if (pcsrc != 0) begin
                e.redir = 1'b1; e.fl = 4'b1100;
            end else if (lw) begin
                e.st = 4'b1100; e.fl = 4'b0100;
            end
            e.start = start;
            e.tout  = to_now;
            if (start) begin
                m_busy = 1; m_run_cycle = 1;
            end else if (m_busy) begin
                if (done_now || to_now) m_busy = 0;
                else m_run_cycle++;
            end
            if (clr) begin
                m_sc = 0; m_rc = 0;
            end else begin
                if (e.st[3] && m_sc < CNT_MAX) m_sc++;
                if (e.redir && m_rc < CNT_MAX) m_rc++;
            end
        end
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        rstn = 1; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        use1 = 0; use2 = 0; resE = 0; wenM = 0; wenW = 0; pcsrc = 0;
        mc_op = 0; mc_done = 0; dreq = 0; drdy = 1; clr = 0;
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("forwardAE", fwdA, e.fa);
                chk("forwardBE", fwdB, e.fb);
                chk("stall", {stF, stD, stE, stM}, e.st);
                chk("flush", {flD, flE, flM, flW}, e.fl);
                chk("redirect", redir, e.redir);
                chk("mc_start", mstart, e.start);
                chk("mc_timeout", mto, e.tout);
                chk("stall_cycles", scnt, e.sc);
                chk("redirect_count", rcnt, e.rc);
            end
        end
    end

    initial begin
        quiet();
        rstn = 0;
        m_busy = 0; m_run_cycle = 0; m_sc = 0; m_rc = 0;
        repeat (2) @(posedge clk);
        #1;
        // Reset forces everything low even with live hazards on the inputs.
        rs1E = 5; rdM = 5; wenM = 1; mc_op = 1; dreq = 1; drdy = 0; pcsrc = 1;
        issue(); issue();
        quiet();
        issue();

        // Forwarding: M wins over W; x0 never forwards; W-only match.
        rs1E = 5; rdM = 5; wenM = 1; rdW = 5; wenW = 1; issue();
        rs1E = 0; issue();
        rs2E = 5; wenM = 0; issue();
        quiet();

        // Load-use on rs2, then the same without use_rs2D.
        resE = 1; rdE = 7; rs2D = 7; use2 = 1; issue();
        quiet(); issue();
        resE = 1; rdE = 7; rs2D = 7; use2 = 0; issue();
        quiet();

        // Multicycle op finishing on RUN cycle 5.
        mc_op = 1;
        repeat (5) issue();
        mc_done = 1; issue();
        quiet(); issue();

        // Watchdog: done never arrives.
        mc_op = 1;
        repeat (9) issue();
        quiet(); issue();

        // Memory wait during RUN.
        mc_op = 1;
        repeat (3) issue();
        dreq = 1; drdy = 0;
        repeat (3) issue();
        drdy = 1; issue();
        mc_done = 1; issue();
        quiet(); issue();

        // Ten load-use stall cycles, then clear.
        clr = 1; issue(); clr = 0;
        resE = 1; rdE = 3; rs1D = 3; use1 = 1;
        repeat (10) issue();
        quiet();
        clr = 1; issue(); clr = 0;
        issue();

        // Twenty redirects saturate a 4-bit counter.
        pcsrc = 2'b01;
        repeat (20) issue();
        quiet(); issue(); issue();

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rstn    = ($urandom_range(0, 199) != 0);
            rs1D    = REG_AW'($urandom_range(0, 7));
            rs2D    = REG_AW'($urandom_range(0, 7));
            rs1E    = REG_AW'($urandom_range(0, 7));
            rs2E    = REG_AW'($urandom_range(0, 7));
            rdE     = REG_AW'($urandom_range(0, 7));
            rdM     = REG_AW'($urandom_range(0, 7));
            rdW     = REG_AW'($urandom_range(0, 7));
            use1    = 1'($urandom_range(0, 1));
            use2    = 1'($urandom_range(0, 1));
            resE    = 1'($urandom_range(0, 1));
            wenM    = 1'($urandom_range(0, 1));
            wenW    = 1'($urandom_range(0, 1));
            pcsrc   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            mc_op   = ($urandom_range(0, 2) == 0);
            mc_done = ($urandom_range(0, 9) == 0);
            dreq    = 1'($urandom_range(0, 1));
            drdy    = ($urandom_range(0, 9) < 7);
            clr     = ($urandom_range(0, 49) == 0);
            issue();
        end
        quiet();
        issue();

        @(negedge clk);
        #1;
        chk("scoreboard_drain", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
